// File: rtl/ulaw_comp.sv
// u-law compressor: 14-bit two's-complement sample to non-inverted {s, seg, mant}
// code, found by an iterative segment search that tests one segment per clock.
module ulaw_comp #(
  parameter int BIAS = 33,
  parameter int CLIP = 8191
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] lin_in,
  output logic [7:0]  enc_out,
  output logic        finish,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ABS, SCAN} state_t;

  state_t      state, state_nx;
  logic [13:0] lin_r;
  logic        s;
  logic [12:0] mag;
  logic [2:0]  seg;

  logic        load;
  logic        done;
  logic        hit;
  logic [12:0] mag_sh;
  logic [14:0] lin_ext;
  logic [14:0] abs_val;
  logic [14:0] biased;
  logic [12:0] clipped;

  // Widen to 15 bits before negating so that -8192 has a positive magnitude.
  assign lin_ext = {lin_r[13], lin_r};
  assign abs_val = lin_r[13] ? (~lin_ext + 15'd1) : lin_ext;
  assign biased  = abs_val + 15'(BIAS);
  assign clipped = (biased > 15'(CLIP)) ? 13'(CLIP) : biased[12:0];

  // Shifting by seg puts the segment's leading bit at 5 and its mantissa at [4:1].
  assign mag_sh = mag >> seg;
  assign hit    = mag_sh[5] || (seg == 3'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: each combinational output gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ABS;
      ABS:     state_nx = SCAN;
      SCAN:    if (hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    load = 1'b0;
    done = 1'b0;
    case (state)
      IDLE:    load = start;
      ABS:     busy = 1'b1;
      SCAN: begin
        busy = 1'b1;
        done = hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lin_r   <= '0;
      s       <= 1'b0;
      mag     <= '0;
      seg     <= 3'd7;
      enc_out <= 8'h00;
      finish  <= 1'b0;
    end else begin
      finish <= done;
      if (load) begin
        lin_r <= lin_in;
        s     <= lin_in[13];
      end
      if (state == ABS) begin
        mag <= clipped;
        seg <= 3'd7;
      end
      if (state == SCAN && !hit) seg <= seg - 3'd1;
      if (done) enc_out <= {s, seg, mag_sh[4:1]};
    end
  end

endmodule

// File: tb/tb_ulaw_comp.sv
// Directed-vector bench for ulaw_comp: table of codes and latencies, handshake
// corner cases, reset abort, and a strided encode/decode loopback sweep.
module tb_ulaw_comp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] lin_in = '0;
  logic [7:0]  enc_out;
  logic        finish;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  ulaw_comp dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .lin_in  (lin_in),
    .enc_out (enc_out),
    .finish  (finish),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] lin;
    logic [7:0]  code;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one conversion; lat counts edges after the accepting edge until finish.
  task automatic run_conv(input logic [13:0] x, output logic [7:0] code,
                          output int lat, output logic got, output logic busy_seen);
    @(negedge clk);
    lin_in = x;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    lin_in    = ~x;
    busy_seen = busy;
    got  = 1'b0;
    lat  = 0;
    code = '0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        got  = 1'b1;
        lat  = i;
        code = enc_out;
        break;
      end
    end
  endtask

  function automatic int decode(input logic [7:0] c);
    int m;
    m = (((int'(c[3:0]) << 1) + 33) << c[6:4]) - 33;
    return c[7] ? -m : m;
  endfunction

  vec_t vecs[10];

  initial begin
    logic [7:0] code;
    int         lat;
    logic       got;
    logic       bsy;
    int         fin_cnt;
    int         pos[3];

    vecs[0] = '{14'sd0,     8'h00, 9};
    vecs[1] = '{-14'sd1,    8'h81, 9};
    vecs[2] = '{14'sd100,   8'h20, 7};
    vecs[3] = '{14'sd1000,  8'h50, 4};
    vecs[4] = '{14'sd8158,  8'h7F, 2};
    vecs[5] = '{-14'sd8192, 8'hFF, 2};
    vecs[6] = '{-14'sd5000, 8'hF3, 2};
    vecs[7] = '{14'sd8159,  8'h7F, 2};
    vecs[8] = '{14'sd31,    8'h10, 8};
    vecs[9] = '{14'sd64,    8'h18, 8};

    // Reset state
    #12;
    check("rst_enc", 32'(enc_out), 32'h00);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      run_conv(vecs[k].lin, code, lat, got, bsy);
      check($sformatf("code[%0d]", k), 32'(code), 32'(vecs[k].code));
      check($sformatf("lat[%0d]", k), 32'(lat), 32'(vecs[k].lat));
      check($sformatf("busy[%0d]", k), 32'(bsy), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("pulse[%0d]", k), 32'({finish, busy}), 32'd0);
    end

    // Start pulsed while busy must be ignored
    @(negedge clk);
    lin_in = 14'sd0;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    lin_in = 14'sd100;
    start  = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    fin_cnt = 0;
    code    = 8'hAA;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        fin_cnt++;
        code = enc_out;
      end
    end
    check("busy_start_count", 32'(fin_cnt), 32'd1);
    check("busy_start_code", 32'(code), 32'h00);

    // Start held high: re-accepted in the IDLE cycle after each completion
    @(negedge clk);
    lin_in = 14'sd8158;
    start  = 1'b1;
    @(posedge clk);
    fin_cnt = 0;
    pos     = '{0, 0, 0};
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        if (fin_cnt < 3) pos[fin_cnt] = n;
        fin_cnt++;
      end
    end
    start = 1'b0;
    check("held_count", 32'(fin_cnt), 32'd3);
    check("held_pos0", 32'(pos[0]), 32'd2);
    check("held_pos1", 32'(pos[1]), 32'd5);
    check("held_pos2", 32'(pos[2]), 32'd8);
    repeat (6) @(posedge clk);

    // Reset mid-SCAN aborts without a finish pulse
    run_conv(14'sd8158, code, lat, got, bsy);
    check("pre_rst_code", 32'(code), 32'h7F);
    @(negedge clk);
    lin_in = 14'sd0;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_enc", 32'(enc_out), 32'h00);
    check("abort_finish", 32'(finish), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    fin_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (finish) fin_cnt++;
    end
    check("abort_no_finish", 32'(fin_cnt), 32'd0);
    check("abort_enc_held", 32'(enc_out), 32'h00);

    // Loopback sweep through a decode model, stride 3 across the full range
    for (int x = -8192; x <= 8191; x += 3) begin
      int d;
      int err;
      int step;
      bit bad;
      run_conv(14'(x), code, lat, got, bsy);
      d    = decode(code);
      err  = (d > x) ? d - x : x - d;
      step = 2 << code[6:4];
      bad  = !got;
      if (d != 0 && ((d < 0) != (x < 0))) bad = 1'b1;
      if (((x < 0 ? -x : x) + 33) > 8191) begin
        if (err > step) bad = 1'b1;
      end else if (err > step / 2) begin
        bad = 1'b1;
      end
      n_vec++;
      if (bad) begin
        n_bad++;
        $display("FAIL loopback x=%0d: code 0x%0h decodes to %0d (finish seen %0b)", x, code, d, got);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
